// File: rtl/switch_debounce.sv
// Debouncer for a bank of board switches and one confirmation push-button.
// Switches share one settle counter; the button uses a 4-state FSM with a sticky confirmation flag.
module switch_debounce #(
  parameter int unsigned DB_CYCLES = 100000,
  parameter int unsigned SW_W      = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SW_W-1:0] rawSwitch,
  input  logic            rawButton,
  input  logic            confirmClear,
  output logic [SW_W-1:0] switchOut,
  output logic            buttonLevel,
  output logic            confirmation,
  output logic            switchChanged
);

  localparam int unsigned     CW      = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0]   CNT_MAX = CW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    LOW_STABLE,
    RISE_PEND,
    HIGH_STABLE,
    FALL_PEND
  } btn_state_t;

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser: button sits on the top bit, switches below it.
  // ---------------------------------------------------------------------------
  logic [SW_W:0] sync_meta;
  logic [SW_W:0] sync_out;
  logic [SW_W-1:0] s_sw;
  logic            s_btn;

  // NOTE: every flop here, synchroniser stages included, is cleared by reset so
  // no half-sampled bounce can survive a reset and leak into the counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= '0;
      sync_out  <= '0;
    end else begin
      // NOTE: non-blocking assignments make both stages sample the old values
      // on the same edge; blocking here would collapse the chain to one flop.
      sync_meta <= {rawButton, rawSwitch};
      sync_out  <= sync_meta;
    end
  end

  assign s_sw  = sync_out[SW_W-1:0];
  assign s_btn = sync_out[SW_W];

  // ---------------------------------------------------------------------------
  // Switch bank: any bit moving restarts the shared count from zero.
  // ---------------------------------------------------------------------------
  logic [SW_W-1:0] cand;
  logic [SW_W-1:0] sw_prev;
  logic [CW-1:0]   sw_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand      <= '0;
      sw_cnt    <= '0;
      switchOut <= '0;
    end else if (s_sw != cand) begin
      cand   <= s_sw;
      sw_cnt <= '0;
    end else if (cand != switchOut) begin
      if (sw_cnt == CNT_MAX) begin
        switchOut <= cand;
        sw_cnt    <= '0;
      end else begin
        sw_cnt <= sw_cnt + CW'(1);
      end
    end else begin
      sw_cnt <= '0;
    end
  end

  // Change pulse lags the switchOut update by one edge, aligned to the new value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_prev       <= '0;
      switchChanged <= 1'b0;
    end else begin
      sw_prev       <= switchOut;
      switchChanged <= (switchOut != sw_prev);
    end
  end

  // ---------------------------------------------------------------------------
  // Button FSM with dedicated counter.
  // ---------------------------------------------------------------------------
  btn_state_t    state;
  btn_state_t    state_nxt;
  logic [CW-1:0] btn_cnt;
  logic [CW-1:0] btn_cnt_nxt;
  logic          conf_set;

  always_comb begin
    // NOTE: defaults first so every path assigns every output; otherwise the
    // missing branches would infer latches.
    state_nxt   = state;
    btn_cnt_nxt = btn_cnt;
    conf_set    = 1'b0;
    unique case (state)
      LOW_STABLE: begin
        if (s_btn) begin
          state_nxt   = RISE_PEND;
          btn_cnt_nxt = '0;
        end
      end
      RISE_PEND: begin
        if (!s_btn) begin
          state_nxt = LOW_STABLE;
        end else if (btn_cnt == CNT_MAX) begin
          state_nxt   = HIGH_STABLE;
          btn_cnt_nxt = '0;
          conf_set    = 1'b1;
        end else begin
          btn_cnt_nxt = btn_cnt + CW'(1);
        end
      end
      HIGH_STABLE: begin
        if (!s_btn) begin
          state_nxt   = FALL_PEND;
          btn_cnt_nxt = '0;
        end
      end
      FALL_PEND: begin
        if (s_btn) begin
          state_nxt = HIGH_STABLE;
        end else if (btn_cnt == CNT_MAX) begin
          state_nxt   = LOW_STABLE;
          btn_cnt_nxt = '0;
        end else begin
          btn_cnt_nxt = btn_cnt + CW'(1);
        end
      end
      default: begin
        state_nxt   = LOW_STABLE;
        btn_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= LOW_STABLE;
      btn_cnt      <= '0;
      buttonLevel  <= 1'b0;
      confirmation <= 1'b0;
    end else begin
      state       <= state_nxt;
      btn_cnt     <= btn_cnt_nxt;
      buttonLevel <= (state_nxt == HIGH_STABLE) || (state_nxt == FALL_PEND);
      // A press arriving with a clear wins so that no press is ever dropped.
      if (conf_set) begin
        confirmation <= 1'b1;
      end else if (confirmClear) begin
        confirmation <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with DB_CYCLES=4: edge-counted latency,
// bounce rejection, confirmation set/clear priority and mid-count reset.
module tb_switch_debounce;

  localparam int unsigned DB   = 4;
  localparam int unsigned SW_W = 16;

  logic            clk;
  logic            rst;
  logic [SW_W-1:0] rawSwitch;
  logic            rawButton;
  logic            confirmClear;
  logic [SW_W-1:0] switchOut;
  logic            buttonLevel;
  logic            confirmation;
  logic            switchChanged;

  int errors = 0;
  int checks = 0;

  switch_debounce #(.DB_CYCLES(DB), .SW_W(SW_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .rawSwitch    (rawSwitch),
    .rawButton    (rawButton),
    .confirmClear (confirmClear),
    .switchOut    (switchOut),
    .buttonLevel  (buttonLevel),
    .confirmation (confirmation),
    .switchChanged(switchChanged)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle; outputs are then "at edge N".
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    rawSwitch    = '0;
    rawButton    = 1'b0;
    confirmClear = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    rawSwitch    = 16'hFFFF;
    rawButton    = 1'b1;
    confirmClear = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (switchOut !== 16'h0000) begin
      errors++;
      $display("FAIL reset_switchOut got=%h exp=0000", switchOut);
    end
    checks++;
    if ({buttonLevel, confirmation, switchChanged} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=000", {buttonLevel, confirmation, switchChanged});
    end
    do_reset();
  endtask

  task automatic test_switch_latency();
    logic [SW_W-1:0] exp_sw;
    rawSwitch = 16'hA5C3;
    for (int e = 1; e <= 10; e++) begin
      tick();
      exp_sw = (e >= 7) ? 16'hA5C3 : 16'h0000;
      checks++;
      if (switchOut !== exp_sw) begin
        errors++;
        $display("FAIL sw_latency edge=%0d switchOut got=%h exp=%h", e, switchOut, exp_sw);
      end
      checks++;
      if (switchChanged !== (e == 8)) begin
        errors++;
        $display("FAIL sw_changed edge=%0d got=%b exp=%b", e, switchChanged, (e == 8));
      end
    end
  endtask

  task automatic test_switch_bounce();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      rawSwitch = (((i / 2) % 2) == 0) ? 16'h0001 : 16'h0000;
      tick();
      checks++;
      if (switchOut !== 16'h0000 || switchChanged !== 1'b0) begin
        errors++;
        $display("FAIL sw_bounce cycle=%0d switchOut got=%h chg=%b exp=0000/0", i, switchOut, switchChanged);
      end
    end
    rawSwitch = 16'h0001;
    for (int e = 1; e <= 9; e++) begin
      tick();
      checks++;
      if (switchOut !== ((e >= 7) ? 16'h0001 : 16'h0000)) begin
        errors++;
        $display("FAIL sw_settle edge=%0d switchOut got=%h exp=%h", e, switchOut,
                 (e >= 7) ? 16'h0001 : 16'h0000);
      end
    end
  endtask

  task automatic test_button_glitch();
    do_reset();
    rawButton = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    rawButton = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      checks++;
      if (buttonLevel !== 1'b0 || confirmation !== 1'b0) begin
        errors++;
        $display("FAIL btn_glitch cycle=%0d level=%b conf=%b exp=0/0", e, buttonLevel, confirmation);
      end
    end
  endtask

  task automatic test_button_press();
    do_reset();
    rawButton = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      checks++;
      if (confirmation !== (e >= 7) || buttonLevel !== (e >= 7)) begin
        errors++;
        $display("FAIL btn_press edge=%0d conf=%b level=%b exp=%b", e, confirmation, buttonLevel, (e >= 7));
      end
    end
    rawButton = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      checks++;
      if (confirmation !== 1'b1 || buttonLevel !== (e < 7)) begin
        errors++;
        $display("FAIL btn_release edge=%0d conf=%b level=%b exp=1/%b", e, confirmation, buttonLevel, (e < 7));
      end
    end
  endtask

  task automatic test_clear_collision();
    do_reset();
    rawButton = 1'b1;
    for (int e = 1; e <= 6; e++) tick();
    checks++;
    if (confirmation !== 1'b0) begin
      errors++;
      $display("FAIL collide_pre got=%b exp=0", confirmation);
    end
    confirmClear = 1'b1;
    tick();
    confirmClear = 1'b0;
    checks++;
    if (confirmation !== 1'b1) begin
      errors++;
      $display("FAIL collide_set_wins got=%b exp=1", confirmation);
    end
    tick();
    tick();
    confirmClear = 1'b1;
    tick();
    confirmClear = 1'b0;
    checks++;
    if (confirmation !== 1'b0) begin
      errors++;
      $display("FAIL later_clear got=%b exp=0", confirmation);
    end
    rawButton = 1'b0;
    for (int i = 0; i < 8; i++) tick();
  endtask

  task automatic test_reset_midpress();
    do_reset();
    rawSwitch = 16'h1234;
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (switchOut !== 16'h1234) begin
      errors++;
      $display("FAIL midrst_pre_sw got=%h exp=1234", switchOut);
    end
    rawButton = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (buttonLevel !== 1'b0) begin
      errors++;
      $display("FAIL midrst_pending level got=%b exp=0", buttonLevel);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (switchOut !== 16'h0000 || {buttonLevel, confirmation, switchChanged} !== 3'b000) begin
      errors++;
      $display("FAIL midrst_async sw=%h flags=%b exp=0000/000", switchOut,
               {buttonLevel, confirmation, switchChanged});
    end
    tick();
    tick();
    rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      checks++;
      if (confirmation !== (e >= 7) || switchOut !== ((e >= 7) ? 16'h1234 : 16'h0000)) begin
        errors++;
        $display("FAIL midrst_recover edge=%0d conf=%b sw=%h exp=%b/%h", e, confirmation, switchOut,
                 (e >= 7), (e >= 7) ? 16'h1234 : 16'h0000);
      end
    end
  endtask

  task automatic test_held_clear();
    logic exp_c;
    do_reset();
    rawButton = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      confirmClear = (i == 50);
      tick();
      exp_c = (i >= 7) && (i < 50);
      checks++;
      if (confirmation !== exp_c) begin
        errors++;
        $display("FAIL held_clear cycle=%0d got=%b exp=%b", i, confirmation, exp_c);
      end
    end
    confirmClear = 1'b0;
    rawButton    = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (confirmation !== 1'b0 || buttonLevel !== 1'b0) begin
      errors++;
      $display("FAIL held_release conf=%b level=%b exp=0/0", confirmation, buttonLevel);
    end
    rawButton = 1'b1;
    for (int e = 1; e <= 7; e++) tick();
    checks++;
    if (confirmation !== 1'b1) begin
      errors++;
      $display("FAIL held_repress got=%b exp=1", confirmation);
    end
  endtask

  initial begin
    rst          = 1'b1;
    rawSwitch    = '0;
    rawButton    = 1'b0;
    confirmClear = 1'b0;
    test_reset();
    test_switch_latency();
    test_switch_bounce();
    test_button_glitch();
    test_button_press();
    test_clear_collision();
    test_reset_midpress();
    test_held_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
